gray_seq_controller: RTL
========================

Name: gray_seq_controller

Overview:
- Sequencer for an N-bit Gray code generator. Accepts start/stop commands and runs the Gray sequence in one-shot mode (a fixed number of codes) or continuous mode.
- Presents codes to a downstream consumer over a valid/ready handshake. Output is fully registered, so no combinational glitches reach the consumer.
- Sits between the control/CSR logic and any Gray-coded consumer, such as a pointer, encoder or sequence stimulus.

Parameters:
- WIDTH, 3, Gray code width in bits.
- CNT_W, 8, width of the step-count field and internal step counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; begin a run (honoured only in IDLE).
- stop  input  1  level or pulse; abort a run (honoured only in RUN).
- mode  input  1  0 = one-shot, 1 = continuous; sampled at accepted start.
- dir  input  1  0 = count up, 1 = count down; sampled at accepted start.
- num_steps  input  CNT_W  codes to emit in one-shot mode; sampled at accepted start.
- gray_out  output  WIDTH  current Gray code, registered.
- gray_valid  output  1  gray_out holds a valid code.
- gray_ready  input  1  consumer accepts gray_out when valid && ready.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at end of a one-shot run or an abort.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) forces the following, regardless of in-flight activity:
  - state = IDLE.
  - gray_out = 0, gray_valid = 0, busy = 0, done = 0.
  - Internal binary count = 0, step counter = 0, latched mode/dir = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mode, dir and num_steps, clears the binary count to 0 and loads the step counter with num_steps.
  - If mode=1, or mode=0 with num_steps!=0: go to RUN. gray_valid=1 and gray_out=0 in the next cycle, so latency from start is 1 cycle.
  - If mode=0 and num_steps==0: go to DONE. No code is emitted.
- RUN:
  - Transfer = gray_valid && gray_ready.
  - On transfer, the binary count moves +1 (dir=0) or -1 (dir=1) modulo 2^WIDTH, wrapping 7->0 up and 0->7 down for WIDTH=3.
  - gray_out is registered as next_bin ^ (next_bin >> 1), so exactly one bit changes per transfer, including at wrap.
  - Backpressure: while gray_valid && !gray_ready, gray_out and the count hold stable.
  - One-shot: the step counter decrements on each transfer. The transfer that takes it from 1 to 0 moves the FSM to DONE, with gray_valid=0 in the next cycle.
  - Continuous: the step counter is unused and the run continues indefinitely.
  - stop=1 goes to DONE next cycle with gray_valid=0. If stop and a transfer coincide, the transfer completes and counts.
  - stop has priority over the last-step completion; both lead to DONE, so there is no conflict.
  - start is ignored in RUN.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE.
- Output ownership: gray_out retains the last emitted code after the run; it is only meaningful while gray_valid=1.
- stop in IDLE or DONE is ignored.
- Reset mid-RUN: the in-flight code is dropped, no done pulse is issued, and the bench must not expect a final transfer.
- Sampled configuration is frozen during a run; changing mode, dir or num_steps mid-run has no effect.
- Emitted sequence for WIDTH=3:
  - Up: 000, 001, 011, 010, 110, 111, 101, 100, 000 …
  - Down: 000, 100, 101, 111, 110, 010, 011, 001, 000 …

Test Plan:
1. One-shot up: mode=0, dir=0, num_steps=5, gray_ready=1 held → 5 transfers of 000, 001, 011, 010, 110 on consecutive cycles starting 1 cycle after start; done pulses 1 cycle after the last transfer; busy low afterwards.
2. Wrap and down: mode=0, dir=1, num_steps=9 → 000, 100, 101, 111, 110, 010, 011, 001, 000. Check the single-bit Hamming distance between every consecutive pair, including the wrap.
3. Backpressure: one-shot up, num_steps=4, gray_ready low on cycles 2–4 of the run → gray_out holds 001 while stalled; total transfers = 4; sequence unchanged; done only after the 4th transfer.
4. Continuous and stop: mode=1, dir=0, gray_ready=1, stop asserted on the cycle gray_out=111 → 111 is accepted, gray_valid=0 next cycle, done pulses once, FSM returns to IDLE. Repeat with stop during a stall: no transfer occurs, done pulses.
5. Zero steps and ignored commands: start with mode=0, num_steps=0 → no gray_valid, done pulses the cycle after start. start pulsed during RUN → ignored, run length unchanged. stop in IDLE → no effect.
6. Reset mid-run: continuous run, rst=1 for 1 cycle while gray_out=011 → at the next edge all outputs are 0 and the FSM is IDLE with no done pulse. A fresh start then emits from 000.

Source files
------------

// File: rtl/gray_seq_controller_if.sv
// ============================================================================
// Module      : gray_seq_controller_if
// Description : Valid/ready handshake carrying Gray codes to a consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_seq_controller_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] gray_out;
    logic             gray_valid;
    logic             gray_ready;

    modport master (
        output gray_out,
        output gray_valid,
        input  gray_ready
    );

    modport slave (
        input  gray_out,
        input  gray_valid,
        output gray_ready
    );
endinterface

`default_nettype wire

// File: rtl/gray_seq_controller.sv
// ============================================================================
// Module      : gray_seq_controller
// Description : One-shot / continuous Gray code sequencer with registered
//               valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_seq_controller #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             stop,
    input  wire logic             mode,
    input  wire logic             dir,
    input  wire logic [CNT_W-1:0] num_steps,
    output logic                  busy,
    output logic                  done,
    gray_seq_controller_if.master gray_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [WIDTH-1:0]   gray_q, gray_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               mode_q, mode_d;
    logic               dir_q, dir_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [WIDTH-1:0]   bin_nx;
    logic               last_step;

    assign xfer      = valid_q && gray_if.gray_ready;
    assign bin_nx    = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
    assign last_step = !mode_q && (steps_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        gray_d  = gray_q;
        steps_d = steps_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    dir_d   = dir;
                    steps_d = num_steps;
                    bin_d   = '0;
                    busy_d  = 1'b1;
                    if (mode || (num_steps != '0)) begin
                        state_d = ST_RUN;
                        gray_d  = '0;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    bin_d = bin_nx;
                    if (!mode_q) begin
                        steps_d = steps_q - CNT_W'(1);
                    end
                end
                if (stop || (xfer && last_step)) begin
                    // gray_out keeps the last accepted code once the run ends
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (xfer) begin
                    gray_d = bin_nx ^ (bin_nx >> 1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            steps_q <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            steps_q <= steps_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gray_if.gray_out   = gray_q;
    assign gray_if.gray_valid = valid_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

`default_nettype wire
